clkdiv_bank: RTL
================

# clkdiv_bank

Multi-channel programmable clock divider and tick generator, the parametrised successor to the single-channel divider. Each of CHANNELS independent counters divides the system clock by a runtime-programmable terminal count. Each channel produces either a 50% square wave or a one-cycle tick. Sits between the board clock and slow consumers (display multiplexing, debouncers, comparator sampling strobes). Terminal-count updates are glitch-free: they are shadowed and applied only at a counter wrap.

## Interface
- WIDTH, 16, counter and terminal-count width
- CHANNELS, 4, number of independent divider channels (1..16)
- TC_INIT, 16'd49999, terminal count loaded into every channel at reset
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset rst, synchronous, active-high
- en  input  CHANNELS  per-channel count enable
- mode  input  CHANNELS  per-channel output mode: 0 = toggle (square wave on clk_div), 1 = pulse (tick only)
- tc_wr  input  1  terminal-count write strobe
- tc_sel  input  4  channel index for tc_wr
- tc_data  input  WIDTH  new terminal count
- clk_div  output  CHANNELS  registered divided clock per channel
- tick  output  CHANNELS  registered one-cycle pulse per channel wrap
- sync  input  1  present only with CLKDIV_SYNC_EN (see Configuration)

## Operation
- Per channel state: count[WIDTH], active_tc[WIDTH], pending_tc[WIDTH], pending_vld, clk_div, tick.
- Reset (rst=1 at a clk edge): count=0, active_tc=pending_tc=TC_INIT, pending_vld=0, clk_div=0, tick=0 on all channels. tc_wr is ignored while rst=1.
- Wrap condition for channel i: en[i]=1 and count==active_tc.
- en[i]=1, no wrap: count increments by 1.
- On wrap:
  - count<=0
  - tick<=1
  - if mode[i]=0, clk_div toggles
  - if pending_vld, active_tc<=pending_tc and pending_vld<=0
- en[i]=0:
  - count and clk_div hold; tick=0
  - if pending_vld, active_tc<=pending_tc immediately and pending_vld<=0
- mode[i]=1: clk_div<=0 on the next edge and stays 0. The counter and tick are unaffected by mode.
- tc_wr=1 with tc_sel<CHANNELS: pending_tc[tc_sel]<=tc_data, pending_vld<=1.
  - If two writes land before a wrap, the last write wins.
  - A write in the same cycle as a wrap is not applied at that wrap; it takes effect at the following wrap.
- tc_wr=1 with tc_sel>=CHANNELS: write ignored, no state change.
- Arithmetic: unsigned, WIDTH bits. count never exceeds active_tc, because a new tc only becomes active with count=0 or while disabled with count<=old tc.
  - Corner case: disabled with count > new active_tc. The next enabled cycle increments; the wrap occurs at 2^WIDTH-1 followed by rollover to 0, and no tick fires on the rollover.
  - This case is documented and tested, not corrected.

## Timing
- tick period = active_tc+1 cycles; tick high exactly 1 cycle, asserted in the cycle after the wrap cycle.
- Toggle-mode clk_div period = 2*(active_tc+1) cycles, 50% duty. clk_div changes on the same edge that raises tick.
- active_tc=0: tick constantly high while enabled; clk_div = clk/2.
- Latency en rise -> first tick = active_tc+1 cycles from count=0.
- A tc write becomes visible at the first wrap strictly after the write cycle, or on the next edge if the channel is disabled.
- rst mid-count: all outputs are 0 on the cycle after the rst edge. Counting resumes from 0 on the first edge with rst=0.

## Configuration
- CLKDIV_SYNC_EN defined: adds input port sync (1 bit). sync=1 at an edge, with rst=0, does the following on all channels:
  - count<=0, clk_div<=0, tick<=0
  - pending_tc is applied if valid
  - tc_wr in the same cycle is still captured into pending
  - sync overrides wrap
- This gives phase-aligned restarts across channels.
- CLKDIV_SYNC_EN undefined: no sync port; channels are phase-related only through reset.

## Test plan
- Reset, en=4'b0001, mode=0, TC_INIT=4 -> tick[0] every 5 cycles; clk_div[0] period 10 with 5 high/5 low; other channels all 0.
- Write tc_data=2 to ch1 mid-count (count=3, tc=9) -> ch1 finishes the current period of 10 cycles, then ticks every 3 cycles; other channels unchanged.
- Write ch2 tc=7 then tc=1 before its wrap; also write with tc_sel=5 (CHANNELS=4) -> ch2 adopts 1 (period 2); the out-of-range write changes nothing.
- en=0 on ch3 at count=6 for 10 cycles, then en=1 -> count holds 6, tick=0 while disabled; resumes at 7 and wraps at TC_INIT.
- mode switch 0->1 on ch0 while clk_div=1 -> clk_div=0 next cycle; tick period unchanged. Assert rst mid-count -> all outputs 0 the next cycle.
- (CLKDIV_SYNC_EN) channels with tc 2, 4, 6 at random phases, then pulse sync -> all ticks coincide every LCM(3, 5, 7)=105 cycles, counted from the sync edge.

Source files
------------

// File: rtl/clkdiv_bank_if.sv
// Bus-side signals of the clkdiv_bank divider bank: enables, modes, tc write port and outputs.
// The sync input exists only when CLKDIV_SYNC_EN is defined.
interface clkdiv_bank_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] mode;
  logic                tc_wr;
  logic [3:0]          tc_sel;
  logic [WIDTH-1:0]    tc_data;
  logic [CHANNELS-1:0] clk_div;
  logic [CHANNELS-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic                sync;

  modport master (
    output en, mode, tc_wr, tc_sel, tc_data, sync,
    input  clk_div, tick
  );
  modport slave (
    input  en, mode, tc_wr, tc_sel, tc_data, sync,
    output clk_div, tick
  );
`else
  modport master (
    output en, mode, tc_wr, tc_sel, tc_data,
    input  clk_div, tick
  );
  modport slave (
    input  en, mode, tc_wr, tc_sel, tc_data,
    output clk_div, tick
  );
`endif
endinterface

// File: rtl/clkdiv_bank.sv
// Multi-channel programmable clock divider / tick generator with shadowed terminal counts.
// Optional CLKDIV_SYNC_EN adds a sync input that restarts all channels in phase.
module clkdiv_bank #(
  parameter int               WIDTH    = 16,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] TC_INIT  = 16'd49999
) (
  input logic          clk,
  input logic          rst,
  clkdiv_bank_if.slave bus
);

  logic [WIDTH-1:0]    count_q      [CHANNELS];
  logic [WIDTH-1:0]    count_d      [CHANNELS];
  logic [WIDTH-1:0]    active_tc_q  [CHANNELS];
  logic [WIDTH-1:0]    active_tc_d  [CHANNELS];
  logic [WIDTH-1:0]    pending_tc_q [CHANNELS];
  logic [WIDTH-1:0]    pending_tc_d [CHANNELS];
  logic [CHANNELS-1:0] pending_vld_q, pending_vld_d;
  logic [CHANNELS-1:0] clk_div_q, clk_div_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] wrap, wr_hit, apply_pending;
  logic                sync_in;

`ifdef CLKDIV_SYNC_EN
  assign sync_in = bus.sync;
`else
  assign sync_in = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i]       = count_q[i];
      active_tc_d[i]   = active_tc_q[i];
      pending_tc_d[i]  = pending_tc_q[i];
      pending_vld_d[i] = pending_vld_q[i];
      clk_div_d[i]     = clk_div_q[i];
      tick_d[i]        = 1'b0;
      apply_pending[i] = 1'b0;

      wrap[i]   = bus.en[i] && (count_q[i] == active_tc_q[i]);
      // tc_sel beyond CHANNELS-1 matches no channel, so such writes vanish
      wr_hit[i] = bus.tc_wr && (int'(bus.tc_sel) == i);

      if (sync_in) begin
        count_d[i]       = '0;
        clk_div_d[i]     = 1'b0;
        apply_pending[i] = 1'b1;
      end else if (!bus.en[i]) begin
        apply_pending[i] = 1'b1;
      end else if (wrap[i]) begin
        count_d[i]       = '0;
        tick_d[i]        = 1'b1;
        apply_pending[i] = 1'b1;
        if (!bus.mode[i]) clk_div_d[i] = ~clk_div_q[i];
      end else begin
        count_d[i] = count_q[i] + WIDTH'(1);
      end

      if (apply_pending[i] && pending_vld_q[i]) begin
        active_tc_d[i]   = pending_tc_q[i];
        pending_vld_d[i] = 1'b0;
      end

      if (bus.mode[i]) clk_div_d[i] = 1'b0;

      // A write coinciding with a wrap re-arms pending for the next wrap
      if (wr_hit[i]) begin
        pending_tc_d[i]  = bus.tc_data;
        pending_vld_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]      <= '0;
        active_tc_q[i]  <= TC_INIT;
        pending_tc_q[i] <= TC_INIT;
      end
      pending_vld_q <= '0;
      clk_div_q     <= '0;
      tick_q        <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]      <= count_d[i];
        active_tc_q[i]  <= active_tc_d[i];
        pending_tc_q[i] <= pending_tc_d[i];
      end
      pending_vld_q <= pending_vld_d;
      clk_div_q     <= clk_div_d;
      tick_q        <= tick_d;
    end
  end

  assign bus.clk_div = clk_div_q;
  assign bus.tick    = tick_q;

endmodule
